// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pgrstseq.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__pgrstseq
//
// Power-good reset sequencer. It takes the asynchronous power-good level from
// the analog supply monitor and produces a clean, synchronous, debounced
// active-low reset for one power domain.
//
// The sequencer works in four steps:
//   - It synchronizes PG_IN.
//   - It requires STABLE_CYCLES consecutive good cycles before it releases reset.
//   - After a drop, it holds reset for at least HOLD_CYCLES.
//   - It flags brown-outs with a sticky FAULT bit.
//
// Ports:
//   CLK         in   rising-edge clock for every flop
//   RN          in   asynchronous active-low reset
//   PG_IN       in   asynchronous power-good level
//   CLR_FAULT   in   single-cycle synchronous pulse that clears FAULT
//   RSTN_OUT    out  registered active-low domain reset; high only in ON
//   STATE       out  FSM state: 00 OFF, 01 WAIT, 10 ON, 11 HOLD
//   FAULT       out  sticky brown-out flag, set on every ON->HOLD transition
//   GLITCH_CNT  out  saturating count of aborted debounce attempts
//
// Configuration macro:
//   GF180MCU_FD_SC_MCU9T5V0__PGRSTSEQ_GLITCH_CNT_EN
//     When this macro is defined, the glitch counter is built.
//     When it is undefined, GLITCH_CNT is tied to zero and the counter logic
//     is not built.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__pgrstseq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int HOLD_CYCLES   = 8,
    parameter int GLITCH_W      = 4
) (
    input  logic                CLK,
    input  logic                RN,
    input  logic                PG_IN,
    input  logic                CLR_FAULT,
    output logic                RSTN_OUT,
    output logic [1:0]          STATE,
    output logic                FAULT,
    output logic [GLITCH_W-1:0] GLITCH_CNT
);

    // The shared cycle counter must be able to reach both terminal counts.
    localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ON   = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pg_s;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   rstn_q;
    logic                   fault_q;

`ifdef GF180MCU_FD_SC_MCU9T5V0__PGRSTSEQ_GLITCH_CNT_EN
    logic [GLITCH_W-1:0]    glitch_q;
`endif

    // Multi-flop synchronizer for the analog power-good level.
    // New samples enter at bit 0.
    // The FSM looks only at the last stage, so metastability never reaches it.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PG_IN};
        end
    end

    assign pg_s = sync_q[SYNC_STAGES-1];

    // Sequencer FSM with all outputs registered alongside the state.
    //
    // RSTN_OUT is updated on the same edge that enters or leaves ON. It
    // therefore tracks STATE==ON exactly and comes straight from a flop, so
    // it cannot glitch.
    //
    // The counter restarts from zero on every state change. WAIT and HOLD
    // both use it to time their dwell.
    //
    // FAULT clear is evaluated first and the ON->HOLD set is assigned later
    // in the same block. A set and a clear on the same edge therefore resolve
    // to set.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            rstn_q   <= 1'b0;
            fault_q  <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU9T5V0__PGRSTSEQ_GLITCH_CNT_EN
            glitch_q <= '0;
`endif
        end else begin
            if (CLR_FAULT) begin
                fault_q <= 1'b0;
            end

            case (state_q)
                ST_OFF: begin
                    if (pg_s) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= '0;
                    end
                end

                ST_WAIT: begin
                    if (!pg_s) begin
                        // Power-good dropped before it was stable: abort the debounce.
                        state_q <= ST_OFF;
                        cnt_q   <= '0;
`ifdef GF180MCU_FD_SC_MCU9T5V0__PGRSTSEQ_GLITCH_CNT_EN
                        if (glitch_q != {GLITCH_W{1'b1}}) begin
                            glitch_q <= glitch_q + 1'b1;
                        end
`endif
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= ST_ON;
                        cnt_q   <= '0;
                        rstn_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_ON: begin
                    if (!pg_s) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                        rstn_q  <= 1'b0;
                        fault_q <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    // HOLD ignores pg_s. Any recovery must restart the debounce from OFF.
                    if (cnt_q == HOLD_LAST) begin
                        state_q <= ST_OFF;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_OFF;
                    cnt_q   <= '0;
                    rstn_q  <= 1'b0;
                end
            endcase
        end
    end

    assign STATE    = state_q;
    assign RSTN_OUT = rstn_q;
    assign FAULT    = fault_q;

`ifdef GF180MCU_FD_SC_MCU9T5V0__PGRSTSEQ_GLITCH_CNT_EN
    assign GLITCH_CNT = glitch_q;
`else
    assign GLITCH_CNT = '0;
`endif

endmodule
